// File: rtl/intersection_phase_arbiter.sv
// Demand-actuated highway/farm/pedestrian phase scheduler with round-robin arbitration.
// All phase timing advances on the 1-second tick while go is high.
module intersection_phase_arbiter #(
   parameter int T_PREP   = 2,
   parameter int T_HW_MIN = 10,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 1,
   parameter int T_FARM   = 15,
   parameter int T_WALK   = 10,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       go,
   input  logic       farm_req_1,
   input  logic       farm_req_2,
   input  logic       ped_req,
   output logic [1:0] highway_signal,
   output logic [1:0] farm_signal_1,
   output logic [1:0] farm_signal_2,
   output logic       walk,
   output logic [3:0] phase,
   output logic [2:0] pending
);

   typedef enum logic [3:0] {
      S_INIT        = 4'd0,
      S_HW_PREP     = 4'd1,
      S_HW_GREEN    = 4'd2,
      S_HW_YELLOW   = 4'd3,
      S_ALLRED_A    = 4'd4,
      S_FARM_PREP   = 4'd5,
      S_FARM_GREEN  = 4'd6,
      S_FARM_YELLOW = 4'd7,
      S_WALK        = 4'd8,
      S_ALLRED_B    = 4'd9
   } state_t;

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_RED    = 2'b10;
   localparam logic [1:0] L_PREP   = 2'b11;

   localparam logic [CNT_W-1:0] LIM_PREP   = CNT_W'(T_PREP - 1);
   localparam logic [CNT_W-1:0] LIM_HW_MIN = CNT_W'(T_HW_MIN - 1);
   localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] LIM_FARM   = CNT_W'(T_FARM - 1);
   localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(T_WALK - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [2:0]       pend_q, pend_n;
   logic [2:0]       clr;
   logic             rr, rr_n;
   logic [1:0]       served, served_n;
   logic             adv;
   logic             farm_any;
   logic [CNT_W-1:0] limit;
   state_t           target;

   assign adv      = go & tick;
   assign farm_any = |pend_q[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_INIT;
         count  <= '0;
         pend_q <= 3'b000;
         rr     <= 1'b0;
         served <= 2'b00;
      end else begin
         state  <= state_n;
         count  <= count_n;
         pend_q <= pend_n;
         rr     <= rr_n;
         served <= served_n;
      end
   end

   // Dwell limit and successor for each timed state; ALLRED_A resolves its successor by arbitration.
   always_comb begin
      limit  = LIM_ALLRED;
      target = S_INIT;
      case (state)
         S_INIT:        begin limit = LIM_ALLRED; target = S_HW_PREP;     end
         S_HW_PREP:     begin limit = LIM_PREP;   target = S_HW_GREEN;    end
         S_HW_GREEN:    begin limit = LIM_HW_MIN; target = S_HW_YELLOW;   end
         S_HW_YELLOW:   begin limit = LIM_YELLOW; target = S_ALLRED_A;    end
         S_ALLRED_A: begin
            limit = LIM_ALLRED;
            if (farm_any && pend_q[2]) target = rr ? S_WALK : S_FARM_PREP;
            else if (farm_any)         target = S_FARM_PREP;
            else if (pend_q[2])        target = S_WALK;
            else                       target = S_HW_PREP;
         end
         S_FARM_PREP:   begin limit = LIM_PREP;   target = S_FARM_GREEN;  end
         S_FARM_GREEN:  begin limit = LIM_FARM;   target = S_FARM_YELLOW; end
         S_FARM_YELLOW: begin limit = LIM_YELLOW; target = S_ALLRED_B;    end
         S_WALK:        begin limit = LIM_WALK;   target = S_ALLRED_B;    end
         S_ALLRED_B:    begin limit = LIM_ALLRED; target = S_HW_PREP;     end
         default:       begin limit = LIM_ALLRED; target = S_INIT;        end
      endcase
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      rr_n     = rr;
      served_n = served;
      clr      = 3'b000;
      case (state)
         S_INIT, S_HW_PREP, S_HW_YELLOW, S_FARM_PREP,
         S_FARM_GREEN, S_FARM_YELLOW, S_WALK, S_ALLRED_B: begin
            if (adv) begin
               if (count == limit) begin
                  state_n = target;
                  count_n = '0;
               end else begin
                  count_n = count + 1'b1;
               end
            end
         end
         // Highway green rests with the counter saturated until some request is latched.
         S_HW_GREEN: begin
            if (adv) begin
               if (count == limit) begin
                  if (pend_q != 3'b000) begin
                     state_n = target;
                     count_n = '0;
                  end
               end else begin
                  count_n = count + 1'b1;
               end
            end
         end
         S_ALLRED_A: begin
            if (adv) begin
               if (count == limit) begin
                  state_n = target;
                  count_n = '0;
                  if (farm_any && pend_q[2]) rr_n = ~rr;
                  if (target == S_FARM_PREP) begin
                     served_n = pend_q[1:0];
                     clr[1:0] = pend_q[1:0];
                  end
                  if (target == S_WALK) clr[2] = 1'b1;
               end else begin
                  count_n = count + 1'b1;
               end
            end
         end
         default: begin
            state_n = S_INIT;
            count_n = '0;
         end
      endcase
   end

   // A request arriving in the same cycle as its clear is kept.
   assign pend_n  = (pend_q & ~clr) | {ped_req, farm_req_2, farm_req_1};
   assign pending = pend_q;
   assign phase   = state;

   always_comb begin
      highway_signal = L_RED;
      farm_signal_1  = L_RED;
      farm_signal_2  = L_RED;
      walk           = 1'b0;
      case (state)
         S_HW_PREP:   highway_signal = L_PREP;
         S_HW_GREEN:  highway_signal = L_GREEN;
         S_HW_YELLOW: highway_signal = L_YELLOW;
         S_FARM_PREP: begin
            if (served[0]) farm_signal_1 = L_PREP;
            if (served[1]) farm_signal_2 = L_PREP;
         end
         S_FARM_GREEN: begin
            if (served[0]) farm_signal_1 = L_GREEN;
            if (served[1]) farm_signal_2 = L_GREEN;
         end
         S_FARM_YELLOW: begin
            if (served[0]) farm_signal_1 = L_YELLOW;
            if (served[1]) farm_signal_2 = L_YELLOW;
         end
         S_WALK:      walk = 1'b1;
         default:     ;
      endcase
   end

endmodule
